// File: rtl/fpe_wb_queue.sv
// -----------------------------------------------------------------------------
// fpe_wb_queue
//
// Write-back queue feeding the FPE register-file write mux. Execution-unit
// lane results (64-bit payload + row index + lane select) are buffered in an
// in-order FIFO and issued at most one lane write per cycle. Issue is
// suppressed while the register file raises i_hold; pushes are unaffected.
//
// Optional feature (macro FPE_WBQ_BYPASS_EN):
//   When defined, a push arriving while the queue is empty and not held is
//   forwarded combinationally to the outputs in the same cycle and is not
//   stored. When undefined, every result passes through the FIFO and there is
//   no combinational path from i_* to o_*.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  occupancy counter width
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_data          result payload (64)
//   i_data_v        push request
//   i_rf_idx        destination register row (5)
//   i_rf_mux        destination 64-bit lane within the row (2)
//   o_ready         queue can accept a push this cycle
//   i_hold          register file busy, suppress issue
//   o_data          head payload (64)
//   o_data_v        lane write issued this cycle
//   o_rf_idx        head row index (5)
//   o_rf_mux        head lane select (2)
//   o_count         current occupancy (CNT_W)
//   o_empty         occupancy == 0
//   o_full          occupancy == DEPTH
//   o_overflow      sticky: push attempted while not ready
// -----------------------------------------------------------------------------
module fpe_wb_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      i_data,
  input  logic             i_data_v,
  input  logic [4:0]       i_rf_idx,
  input  logic [1:0]       i_rf_mux,
  output logic             o_ready,
  input  logic             i_hold,
  output logic [63:0]      o_data,
  output logic             o_data_v,
  output logic [4:0]       o_rf_idx,
  output logic [1:0]       o_rf_mux,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 71;

  // Entry layout: {data[63:0], idx[4:0], mux[1:0]}
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic             empty;
  logic             full;
  logic             bypass;
  logic             push;
  logic             issue;
  logic [ENT_W-1:0] head;

  // Status flags, push/issue qualification and optional bypass detection
  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
    head  = mem[rd_ptr];
`ifdef FPE_WBQ_BYPASS_EN
    // Empty, not held: forward the incoming result instead of storing it
    bypass = empty && !i_hold && i_data_v;
`else
    bypass = 1'b0;
`endif
    // A full queue refuses pushes even when an issue frees a slot this cycle
    push  = i_data_v && !full && !bypass;
    issue = !empty && !i_hold;
  end

  // Output drive: head of queue, or the forwarded input during bypass
  always_comb begin
    o_ready    = !full;
    o_empty    = empty;
    o_full     = full;
    o_count    = count;
    o_overflow = overflow;
    o_data_v   = issue || bypass;
    if (bypass) begin
      o_data   = i_data;
      o_rf_idx = i_rf_idx;
      o_rf_mux = i_rf_mux;
    end else begin
      o_data   = head[70:7];
      o_rf_idx = head[6:2];
      o_rf_mux = head[1:0];
    end
  end

  // Entry storage; cleared on reset so outputs read zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {i_data, i_rf_idx, i_rf_mux};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and issue leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a push against a full queue is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (i_data_v && full) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_fpe_wb_queue.sv
module tb_fpe_wb_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [63:0]      i_data;
  logic             i_data_v;
  logic [4:0]       i_rf_idx;
  logic [1:0]       i_rf_mux;
  logic             o_ready;
  logic             i_hold;
  logic [63:0]      o_data;
  logic             o_data_v;
  logic [4:0]       o_rf_idx;
  logic [1:0]       o_rf_mux;
  logic [CNT_W-1:0] o_count;
  logic             o_empty;
  logic             o_full;
  logic             o_overflow;

  int tests = 0;
  int fails = 0;

  logic [70:0] sb[$];     // expected issue order {data, idx, mux}
  logic        exp_ovf;

  fpe_wb_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_data_v(i_data_v), .i_rf_idx(i_rf_idx), .i_rf_mux(i_rf_mux),
    .o_ready(o_ready), .i_hold(i_hold),
    .o_data(o_data), .o_data_v(o_data_v), .o_rf_idx(o_rf_idx), .o_rf_mux(o_rf_mux),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, check all
  // outputs against the scoreboard model, then wait for the next falling edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [4:0] idx,
                       input logic [1:0] mux, input logic hold);
    int          pre;
    logic        byp;
    logic        acc;
    logic        exp_v;
    logic [70:0] e;
    i_data_v = v; i_data = d; i_rf_idx = idx; i_rf_mux = mux; i_hold = hold;
    #1;
    pre = sb.size();
    byp = 1'b0;
`ifdef FPE_WBQ_BYPASS_EN
    byp = (pre == 0) && !hold && v;
`endif
    acc   = v && (pre < DEPTH);
    exp_v = ((pre != 0) && !hold) || byp;
    check("count", 64'(o_count), 64'(pre));
    check("empty", 64'(o_empty), 64'(pre == 0));
    check("full", 64'(o_full), 64'(pre == DEPTH));
    check("ready", 64'(o_ready), 64'(pre < DEPTH));
    check("overflow", 64'(o_overflow), 64'(exp_ovf));
    check("data_v", 64'(o_data_v), 64'(exp_v));
    if (acc) sb.push_back({d, idx, mux});
    if (exp_v && sb.size() > 0) begin
      e = sb.pop_front();
      check("data", o_data, e[70:7]);
      check("rf_idx", 64'(o_rf_idx), 64'(e[6:2]));
      check("rf_mux", 64'(o_rf_mux), 64'(e[1:0]));
      check("no_dead", 64'(o_data == 64'hDEAD), 64'(0));
    end
    if (v && !acc) exp_ovf = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic hold);
    for (int k = 0; k < n; k++) cycle(1'b0, 64'h0, 5'd0, 2'd0, hold);
  endtask

  // Apply reset for one cycle and check the cleared state while it is held
  task automatic do_reset();
    rst = 1'b1;
    i_data_v = 1'b0; i_hold = 1'b0;
    #1;
    sb.delete();
    exp_ovf = 1'b0;
    check("rst_count", 64'(o_count), 64'(0));
    check("rst_data_v", 64'(o_data_v), 64'(0));
    check("rst_overflow", 64'(o_overflow), 64'(0));
    check("rst_empty", 64'(o_empty), 64'(1));
    check("rst_ready", 64'(o_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_data = 64'h0; i_data_v = 1'b0; i_rf_idx = 5'd0; i_rf_mux = 2'd0;
    i_hold = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    do_reset();
    // Reset leaves a zeroed array visible at the head
    check("rst_o_data", o_data, 64'h0);
    check("rst_o_idx", 64'(o_rf_idx), 64'(0));
    check("rst_o_mux", 64'(o_rf_mux), 64'(0));

    // Single push, no hold
    cycle(1'b1, 64'h1111_2222_3333_4444, 5'd3, 2'd2, 1'b0);
    idle(2, 1'b0);

    // Fill under hold, then overflow attempt with 0xDEAD
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 64'(k), 5'(k), 2'(k), 1'b1);
    cycle(1'b1, 64'hDEAD, 5'd1, 2'd1, 1'b1);
    cycle(1'b1, 64'hDEAD, 5'd1, 2'd1, 1'b0);  // full, issuing: still refused
    idle(DEPTH, 1'b0);
    idle(1, 1'b0);

    // Sustained push+issue, pointers wrap
    for (int k = 0; k < 20; k++) cycle(1'b1, 64'(100 + k), 5'(k), 2'(k), 1'b0);
    idle(2, 1'b0);

    // Fill to 5 then reset mid-stream
    for (int k = 0; k < 5; k++) cycle(1'b1, 64'(200 + k), 5'd9, 2'(k), 1'b1);
    do_reset();
    cycle(1'b1, 64'h5, 5'd5, 2'd1, 1'b0);
    idle(2, 1'b0);

    // Same row, all four lanes back-to-back, then a held one released
    for (int k = 0; k < 4; k++) cycle(1'b1, 64'(300 + k), 5'd7, 2'(k), 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 64'h77, 5'd7, 2'd3, 1'b1);
    idle(2, 1'b1);
    idle(2, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
